datapath_two_reg: RTL and testbench
===================================

Name: datapath_two_reg

Overview:
- Single-bus 32-bit CPU datapath slice for ALU bring-up: MDR, MAR, PC, IR, Y, 64-bit Z, HI, LO and two general registers, R2 and R6.
- All register-transfer steps are driven by discrete control strobes from an external sequencer; a 32-to-5 encoder selects the bus source.
- Sits between the control unit and memory; memory read data arrives on Mdatain.

Parameters:
- WIDTH, 32, datapath/bus width; Z is 2*WIDTH.

Ports:
- Clock  in  1  rising-edge clock
- Clear  in  1  asynchronous active-low reset
- PCout, Zlowout, Zhighout, MDRout, R2out, R6out  in  1 each  bus-source selects
- R0out, R1out, R3out, R4out, R5out, R7out..R15out, LOout, HIout, Cout, InPortout  in  1 each  bus-source selects
- MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, R2in, R6in, LOin, HIin  in  1 each  register load enables
- IncPC  in  1  PC increment
- Read  in  1  MDR input mux: 1 = Mdatain, 0 = bus
- AND  in  1  reserved strobe; no functional effect
- Mdatain  in  32  memory read data
- operation  in  5  ALU op code
- encoder_input  out  32  one-hot-ish source-select vector presented to the bus encoder

Behaviour:
- encoder_input bit map:
  - [15:0] = R0out..R15out
  - 16 = HIout, 17 = LOout, 18 = Zhighout, 19 = Zlowout, 20 = PCout, 21 = MDRout, 22 = InPortout, 23 = Cout
  - [31:24] = 0
- Encoder is combinational: lowest-index asserted bit wins, giving a 5-bit code. No bit asserted: bus = 0.
- Bus sources:
  - R2 and R6 drive their register values.
  - R0, R1, R3..R5, R7..R15 and InPort drive 0 (not implemented).
  - C drives sign-extended IR[18:0].
- All registers update on rising Clock when their enable is high; Clear low sets every register to 0 asynchronously.
- PC: IncPC = 1 gives PC+1 (takes precedence over PCin); else PCin = 1 loads the bus. PC+1 wraps 0xFFFFFFFF to 0.
- MDR loads on MDRin from Mdatain when Read = 1, else from the bus.
- MAR, IR, Y, R2, R6, HI and LO load from the bus on their enables.
- ALU is combinational: A = Y, B = bus, 64-bit result C.
- Zlowin loads Z[31:0] = C[31:0]; Zhighin loads Z[63:32] = C[63:32]; both may load in the same edge.
- Op codes (C[63:32] = 0 unless stated):
  - 00011 add, 00100 sub (A-B), 00101 and, 00110 or
  - 00111 shr (logical), 01000 shra, 01001 shl, 01010 ror, 01011 rol; shift amount = B[4:0]
  - 10000 mul: signed 32x32 to 64-bit in C
  - 10001 div: see Optional Feature
  - 10010 neg (-B), 10011 not (~B)
  - All other codes: C = 0.

Optional Feature:
- Macro DATAPATH_DIV_EN.
- Defined: op 10001 gives signed A/B, quotient in C[31:0] and remainder in C[63:32]. B = 0 gives C = 0.
- Undefined: no divider is synthesized and op 10001 gives C = 0.

Decomposition:
- Package datapath_pkg holds:
  - op-code localparams (OP_ADD..OP_NOT, OP_MUL = 5'b10000)
  - encoder bit-index constants
  - the 5-bit source-code constants
- One sub-module, alu, holding the combinational ALU (A, B, operation to 64-bit C).
- Encoder and bus mux stay inline.

Test Plan:
- Clear low mid-run -> all registers read 0 immediately; with no select asserted, bus = 0.
- Mdatain = 0x7F000022, Read = 1, MDRin one edge, then MDRout + R2in -> R2 = 0x7F000022. Repeat with 0x7F000024 into R6.
- R2out + Yin, then R6out with operation = 10000 and Zlowin + Zhighin -> Z = 0x3F010022_BA0004C8. Then Zlowout + LOin gives LO = 0xBA0004C8; Zhighout + HIin gives HI = 0x3F010022.
- PCout and MDRout asserted together with MARin -> MAR = PC (lowest index wins).
- PC = 0xFFFFFFFF with IncPC and PCin -> PC = 0.
- Y = 5, bus = 7: sub -> Z low = 0xFFFFFFFE. With DATAPATH_DIV_EN, Y = -7, bus = 2: div -> LO-half 0xFFFFFFFD, HI-half 0xFFFFFFFF.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the datapath_two_reg slice: ALU op codes, encoder
// bit positions and the 5-bit bus-source codes produced by the encoder.
package datapath_pkg;

  // ALU op codes
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b10001;
  localparam logic [4:0] OP_NEG  = 5'b10010;
  localparam logic [4:0] OP_NOT  = 5'b10011;

  // Bit positions inside encoder_input (R0..R15 occupy bits 0..15)
  localparam int unsigned ENC_HI     = 16;
  localparam int unsigned ENC_LO     = 17;
  localparam int unsigned ENC_ZHIGH  = 18;
  localparam int unsigned ENC_ZLOW   = 19;
  localparam int unsigned ENC_PC     = 20;
  localparam int unsigned ENC_MDR    = 21;
  localparam int unsigned ENC_INPORT = 22;
  localparam int unsigned ENC_C      = 23;

  // Source codes: the encoder output equals the winning bit index
  localparam logic [4:0] SRC_R2     = 5'd2;
  localparam logic [4:0] SRC_R6     = 5'd6;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHIGH  = 5'd18;
  localparam logic [4:0] SRC_ZLOW   = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_C      = 5'd23;

  // Width of the immediate carried in IR and sign-extended onto the bus
  localparam int unsigned IMM_W = 19;

endpackage

// File: rtl/datapath_two_reg_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result C.
// Optional signed divider enabled by macro DATAPATH_DIV_EN.
module alu
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         operation,
  output logic [2*WIDTH-1:0] c
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   sra;

  assign sh    = b[SHW-1:0];
  // Sign-extend both operands so the truncated 2W-bit product is the signed result
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign product = a_ext * b_ext;
  assign sra   = $signed(a) >>> sh;

`ifdef DATAPATH_DIV_EN
  logic signed [WIDTH-1:0] quo;
  logic signed [WIDTH-1:0] rem;
  // Signed divide; a zero divisor forces a zero result
  always_comb begin
    quo = '0;
    rem = '0;
    if (b != '0) begin
      quo = $signed(a) / $signed(b);
      rem = $signed(a) % $signed(b);
    end
  end
`endif

  // Operation decode; high half is zero except for mul/div
  always_comb begin
    c = '0;
    case (operation)
      OP_ADD:  c[WIDTH-1:0] = a + b;
      OP_SUB:  c[WIDTH-1:0] = a - b;
      OP_AND:  c[WIDTH-1:0] = a & b;
      OP_OR:   c[WIDTH-1:0] = a | b;
      OP_SHR:  c[WIDTH-1:0] = a >> sh;
      OP_SHRA: c[WIDTH-1:0] = sra;
      OP_SHL:  c[WIDTH-1:0] = a << sh;
      OP_ROR:  c[WIDTH-1:0] = (a >> sh) | (a << (WIDTH - 32'(sh)));
      OP_ROL:  c[WIDTH-1:0] = (a << sh) | (a >> (WIDTH - 32'(sh)));
      OP_MUL:  c = product;
`ifdef DATAPATH_DIV_EN
      OP_DIV:  c = {rem, quo};
`endif
      OP_NEG:  c[WIDTH-1:0] = '0 - b;
      OP_NOT:  c[WIDTH-1:0] = ~b;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/datapath_two_reg.sv
// Single-bus datapath slice: MDR, MAR, PC, IR, Y, Z, HI, LO, R2, R6.
// Optional signed divider in the ALU enabled by macro DATAPATH_DIV_EN.
module datapath_two_reg
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             Zhighout,
  input  logic             MDRout,
  input  logic             R2out,
  input  logic             R6out,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R7out,
  input  logic             R8out,
  input  logic             R9out,
  input  logic             R10out,
  input  logic             R11out,
  input  logic             R12out,
  input  logic             R13out,
  input  logic             R14out,
  input  logic             R15out,
  input  logic             LOout,
  input  logic             HIout,
  input  logic             Cout,
  input  logic             InPortout,
  input  logic             MARin,
  input  logic             Zlowin,
  input  logic             Zhighin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             R2in,
  input  logic             R6in,
  input  logic             LOin,
  input  logic             HIin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             AND,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       operation,
  output logic [31:0]      encoder_input
);

  logic [WIDTH-1:0]   mdr, mar, pc, ir, y, hi, lo, r2, r6;
  logic [2*WIDTH-1:0] z;
  logic [2*WIDTH-1:0] alu_c;
  logic [WIDTH-1:0]   bus;
  logic [4:0]         src;
  logic               src_valid;
  logic [WIDTH-1:0]   c_imm;
  logic               unused_bits;

  // AND strobe and upper IR bits have no effect in this slice
  assign unused_bits = AND ^ (^ir[WIDTH-1:IMM_W]);

  assign c_imm = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  // Gather source selects into the encoder vector
  always_comb begin
    encoder_input = '0;
    encoder_input[15:0] = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                           R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    encoder_input[ENC_HI]     = HIout;
    encoder_input[ENC_LO]     = LOout;
    encoder_input[ENC_ZHIGH]  = Zhighout;
    encoder_input[ENC_ZLOW]   = Zlowout;
    encoder_input[ENC_PC]     = PCout;
    encoder_input[ENC_MDR]    = MDRout;
    encoder_input[ENC_INPORT] = InPortout;
    encoder_input[ENC_C]      = Cout;
  end

  // Priority encoder: lowest asserted bit wins
  always_comb begin
    src       = '0;
    src_valid = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!src_valid && encoder_input[i]) begin
        src       = 5'(i);
        src_valid = 1'b1;
      end
    end
  end

  // Bus mux; unimplemented sources and no selection drive zero
  always_comb begin
    bus = '0;
    if (src_valid) begin
      case (src)
        SRC_R2:    bus = r2;
        SRC_R6:    bus = r6;
        SRC_HI:    bus = hi;
        SRC_LO:    bus = lo;
        SRC_ZHIGH: bus = z[2*WIDTH-1:WIDTH];
        SRC_ZLOW:  bus = z[WIDTH-1:0];
        SRC_PC:    bus = pc;
        SRC_MDR:   bus = mdr;
        SRC_C:     bus = c_imm;
        default:   bus = '0;
      endcase
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a         (y),
    .b         (bus),
    .operation (operation),
    .c         (alu_c)
  );

  // Register file update; Clear zeroes everything asynchronously
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      mdr <= '0;
      mar <= '0;
      pc  <= '0;
      ir  <= '0;
      y   <= '0;
      z   <= '0;
      hi  <= '0;
      lo  <= '0;
      r2  <= '0;
      r6  <= '0;
    end else begin
      if (MDRin)   mdr <= Read ? Mdatain : bus;
      if (MARin)   mar <= bus;
      if (IncPC)   pc  <= pc + WIDTH'(1);
      else if (PCin) pc <= bus;
      if (IRin)    ir  <= bus;
      if (Yin)     y   <= bus;
      if (Zlowin)  z[WIDTH-1:0] <= alu_c[WIDTH-1:0];
      if (Zhighin) z[2*WIDTH-1:WIDTH] <= alu_c[2*WIDTH-1:WIDTH];
      if (HIin)    hi  <= bus;
      if (LOin)    lo  <= bus;
      if (R2in)    r2  <= bus;
      if (R6in)    r6  <= bus;
    end
  end

endmodule

// File: tb/tb_datapath_two_reg.sv
// Self-checking bench for datapath_two_reg: table of ALU vectors plus
// hand-written register-transfer sequences.
module tb_datapath_two_reg;
  import datapath_pkg::*;

  logic Clock = 1'b0;
  logic Clear;
  logic PCout, Zlowout, Zhighout, MDRout, R2out, R6out;
  logic R0out, R1out, R3out, R4out, R5out, R7out, R8out, R9out, R10out;
  logic R11out, R12out, R13out, R14out, R15out, LOout, HIout, Cout, InPortout;
  logic MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, R2in, R6in, LOin, HIin;
  logic IncPC, Read, AND;
  logic [31:0] Mdatain;
  logic [4:0]  operation;
  logic [31:0] encoder_input;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 Clock = ~Clock;

  datapath_two_reg #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .R2out(R2out), .R6out(R6out),
    .R0out(R0out), .R1out(R1out), .R3out(R3out), .R4out(R4out), .R5out(R5out),
    .R7out(R7out), .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
    .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out),
    .LOout(LOout), .HIout(HIout), .Cout(Cout), .InPortout(InPortout),
    .MARin(MARin), .Zlowin(Zlowin), .Zhighin(Zhighin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .R2in(R2in), .R6in(R6in), .LOin(LOin), .HIin(HIin),
    .IncPC(IncPC), .Read(Read), .AND(AND),
    .Mdatain(Mdatain), .operation(operation), .encoder_input(encoder_input)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  task automatic ctrl_idle();
    {PCout, Zlowout, Zhighout, MDRout, R2out, R6out} = '0;
    {R0out, R1out, R3out, R4out, R5out, R7out, R8out, R9out, R10out} = '0;
    {R11out, R12out, R13out, R14out, R15out, LOout, HIout, Cout, InPortout} = '0;
    {MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, R2in, R6in, LOin, HIin} = '0;
    {IncPC, Read, AND} = '0;
    operation = '0;
  endtask

  // One clock edge, then release all strobes 1 ns later
  task automatic tick();
    @(posedge Clock);
    #1;
    ctrl_idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    load_mdr(a);
    MDRout = 1'b1; Yin = 1'b1;
    tick();
    load_mdr(b);
    MDRout = 1'b1; operation = op; Zlowin = 1'b1; Zhighin = 1'b1;
    tick();
  endtask

  initial begin
    ctrl_idle();
    Mdatain = '0;
    Clear = 1'b0;
    #12;
    check("reset_pc", 64'(dut.pc), 64'h0);
    check("reset_z", dut.z, 64'h0);
    check("idle_bus", 64'(dut.bus), 64'h0);
    @(negedge Clock);
    Clear = 1'b1;
    tick();

    vecs[0]  = '{"add_wrap",   32'h7FFFFFFF, 32'h00000001, OP_ADD,  64'h00000000_80000000};
    vecs[1]  = '{"sub_neg",    32'h00000005, 32'h00000007, OP_SUB,  64'h00000000_FFFFFFFE};
    vecs[2]  = '{"and",        32'hF0F01234, 32'h0FF0FFFF, OP_AND,  64'h00000000_00F01234};
    vecs[3]  = '{"or",         32'hF0000000, 32'h0000000F, OP_OR,   64'h00000000_F000000F};
    vecs[4]  = '{"shr",        32'h80000000, 32'h00000004, OP_SHR,  64'h00000000_08000000};
    vecs[5]  = '{"shra",       32'h80000000, 32'h00000004, OP_SHRA, 64'h00000000_F8000000};
    vecs[6]  = '{"shl31",      32'h00000001, 32'h0000001F, OP_SHL,  64'h00000000_80000000};
    vecs[7]  = '{"shl_b40",    32'h00000003, 32'h00000021, OP_SHL,  64'h00000000_00000006};
    vecs[8]  = '{"ror1",       32'h00000001, 32'h00000001, OP_ROR,  64'h00000000_80000000};
    vecs[9]  = '{"ror0",       32'h12345678, 32'h00000000, OP_ROR,  64'h00000000_12345678};
    vecs[10] = '{"rol4",       32'h80000001, 32'h00000004, OP_ROL,  64'h00000000_00000018};
    vecs[11] = '{"mul_neg",    32'hFFFFFFFF, 32'h00000002, OP_MUL,  64'hFFFFFFFF_FFFFFFFE};
    vecs[12] = '{"neg",        32'h00000000, 32'h00000001, OP_NEG,  64'h00000000_FFFFFFFF};
    vecs[13] = '{"not",        32'h00000000, 32'h0F0F0F0F, OP_NOT,  64'h00000000_F0F0F0F0};
    vecs[14] = '{"undef_op",   32'h12345678, 32'h11111111, 5'b11111, 64'h0};

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i].a, vecs[i].b, vecs[i].op);
      check(vecs[i].name, dut.z, vecs[i].exp);
    end

    // Divide: -7 / 2 gives quotient -3, remainder -1 when enabled
    run_vec(32'hFFFFFFF9, 32'h00000002, OP_DIV);
`ifdef DATAPATH_DIV_EN
    check("div", dut.z, 64'hFFFFFFFF_FFFFFFFD);
    run_vec(32'h00000009, 32'h00000000, OP_DIV);
    check("div_by0", dut.z, 64'h0);
`else
    check("div_off", dut.z, 64'h0);
`endif

    // Memory data into R2 and R6
    load_mdr(32'h7F000022);
    MDRout = 1'b1; R2in = 1'b1; tick();
    check("r2_load", 64'(dut.r2), 64'h7F000022);
    load_mdr(32'h7F000024);
    MDRout = 1'b1; R6in = 1'b1; tick();
    check("r6_load", 64'(dut.r6), 64'h7F000024);

    // Signed multiply R2 * R6 into Z, then move halves to LO/HI
    R2out = 1'b1; Yin = 1'b1; tick();
    R6out = 1'b1; operation = OP_MUL; Zlowin = 1'b1; Zhighin = 1'b1; tick();
    check("mul_z", dut.z, 64'h3F010022_BA0004C8);
    Zlowout = 1'b1; LOin = 1'b1; tick();
    check("lo", 64'(dut.lo), 64'hBA0004C8);
    Zhighout = 1'b1; HIin = 1'b1; tick();
    check("hi", 64'(dut.hi), 64'h3F010022);

    // Zlowin alone keeps the high half
    R6out = 1'b1; operation = OP_ADD; Zlowin = 1'b1; tick();
    check("zlow_only", dut.z, 64'h3F010022_FE000046);

    // MDRin with Read = 0 takes the bus
    R2out = 1'b1; MDRin = 1'b1; Mdatain = 32'hDEADBEEF; tick();
    check("mdr_from_bus", 64'(dut.mdr), 64'h7F000022);

    // Encoder map and lowest-index priority (R0 drives zero over R2)
    R0out = 1'b1; R2out = 1'b1; R15out = 1'b1; HIout = 1'b1; Cout = 1'b1;
    #1;
    check("enc_map", 64'(encoder_input), 64'h00818005);
    check("enc_r0_wins", 64'(dut.bus), 64'h0);
    ctrl_idle();

    // C source: sign-extended IR[18:0]
    load_mdr(32'hABC40000);
    MDRout = 1'b1; IRin = 1'b1; tick();
    Cout = 1'b1; MARin = 1'b1; tick();
    check("c_signext", 64'(dut.mar), 64'hFFFC0000);

    // PC load, then PC and MDR together: PC wins
    load_mdr(32'h00001234);
    MDRout = 1'b1; PCin = 1'b1; tick();
    check("pc_load", 64'(dut.pc), 64'h00001234);
    load_mdr(32'h00005678);
    PCout = 1'b1; MDRout = 1'b1; MARin = 1'b1;
    #1;
    check("enc_pc_mdr", 64'(encoder_input), 64'h00300000);
    tick();
    check("mar_pc_wins", 64'(dut.mar), 64'h00001234);

    // PC wrap; IncPC beats PCin even with a nonzero bus
    load_mdr(32'hFFFFFFFF);
    MDRout = 1'b1; PCin = 1'b1; tick();
    check("pc_max", 64'(dut.pc), 64'hFFFFFFFF);
    MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1; tick();
    check("pc_wrap", 64'(dut.pc), 64'h0);

    // Asynchronous Clear mid-cycle, away from any edge
    #2 Clear = 1'b0;
    #1;
    check("aclr_r2", 64'(dut.r2), 64'h0);
    check("aclr_z", dut.z, 64'h0);
    check("aclr_mdr", 64'(dut.mdr), 64'h0);
    #1 Clear = 1'b1;
    load_mdr(32'h0000BEEF);
    check("after_clear", 64'(dut.mdr), 64'h0000BEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
